// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch unit, its IF/ID register
// and the bench.
//   fetch_state_t : RUN / HALT / ERR state encoding of the fetch FSM
//   HALT_OPCODE   : default instruction word that stops fetching
//   BUBBLE_INST   : instruction word placed in IF/ID for a bubble
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;

  localparam logic [15:0] HALT_OPCODE = 16'hEFFF;
  localparam logic [15:0] BUBBLE_INST = 16'h0000;

endpackage

// File: rtl/fetch_imem_if.sv
// fetch_imem_if: instruction-memory bus between the fetch unit and its memory.
//   imem_addr : byte address driven by the fetcher (master)
//   imem_data : instruction word returned combinationally by the memory (slave)
interface fetch_imem_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/fetch_ifid_reg.sv
// fetch_ifid_reg: IF/ID pipeline register.
//   clk, rst      : clock, asynchronous active-low reset
//   load          : capture inst_in / pc_next_in with valid=1
//   bubble        : load an empty slot (inst 0, pc_next 0, valid 0); wins over load
//   (neither)     : hold
//   inst, pc_next, valid : registered IF/ID contents
module fetch_ifid_reg
  import fetch_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          bubble,
  input  logic [DW-1:0] inst_in,
  input  logic [AW-1:0] pc_next_in,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] pc_next,
  output logic          valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst    <= DW'(BUBBLE_INST);
      pc_next <= '0;
      valid   <= 1'b0;
    end else if (bubble) begin
      inst    <= DW'(BUBBLE_INST);
      pc_next <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      inst    <= inst_in;
      pc_next <= pc_next_in;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, RUN/HALT/ERR state machine and
// IF/ID register.
//   clk, rst     : clock, asynchronous active-low reset
//   imem         : fetch_imem_if.master (imem_addr out = PC, imem_data in)
//   stall        : hold PC, IF/ID and state
//   br_taken     : redirect to {br_target[15:1],1'b0}, bubble IF/ID
//   br_target    : redirect byte address
//   ifid_inst, ifid_pc_next, ifid_valid : IF/ID contents
//   halted       : registered, equals (state == HALT)
//   exc          : sticky out-of-range fetch exception
//   dbg_state    : current FSM state for observation
// Optional feature macro FETCH_BOUNDS_EXC_EN: fetching at PC/2 >= INST_MEM_SIZE
// raises exc and parks the unit in ERR (left only by reset). Without it exc
// stays 0 and out-of-range fetches proceed like any other.
//
// Control semantics: br_taken beats stall; stall beats normal fetch. A
// redirect in ERR is ignored except that IF/ID keeps its bubble.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                            INST_ADDR_WIDTH     = 16,
  parameter int                            INST_DATA_BIT_WIDTH = 16,
  parameter int                            INST_MEM_SIZE       = 26,
  parameter logic [INST_ADDR_WIDTH-1:0]    RESET_PC            = '0,
  parameter logic [INST_DATA_BIT_WIDTH-1:0] HALT_OPCODE        = fetch_pkg::HALT_OPCODE
) (
  input  logic                           clk,
  input  logic                           rst,
  fetch_imem_if.master                   imem,
  input  logic                           stall,
  input  logic                           br_taken,
  input  logic [INST_ADDR_WIDTH-1:0]     br_target,
  output logic [INST_DATA_BIT_WIDTH-1:0] ifid_inst,
  output logic [INST_ADDR_WIDTH-1:0]     ifid_pc_next,
  output logic                           ifid_valid,
  output logic                           halted,
  output logic                           exc,
  output fetch_state_t                   dbg_state
);

  localparam int AW = INST_ADDR_WIDTH;
  localparam logic [AW-1:0] MEM_WORDS = AW'(INST_MEM_SIZE);

`ifdef FETCH_BOUNDS_EXC_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  fetch_state_t  state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus2;
  logic          oob;
  logic          is_halt;
  logic          ifid_load;
  logic          ifid_bubble;

  // Address comes straight from the PC register: no input reaches imem_addr.
  assign imem.imem_addr = pc;
  assign dbg_state      = state;

  assign pc_plus2 = pc + AW'(2);   // wraps modulo 2^AW
  assign oob      = BOUNDS_EN && ((pc >> 1) >= MEM_WORDS);
  assign is_halt  = (imem.imem_data == HALT_OPCODE);

  // A live fetch in RUN latches the word (including the halt word itself);
  // HALT/ERR and out-of-range fetches feed bubbles while not stalled.
  assign ifid_load   = !br_taken && !stall && (state == RUN) && !oob;
  assign ifid_bubble = br_taken ||
                       (!stall && ((state != RUN) || oob));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      state  <= RUN;
      halted <= 1'b0;
      exc    <= 1'b0;
    end else if (br_taken) begin
      if (state != ERR) begin
        pc     <= {br_target[AW-1:1], 1'b0};
        state  <= RUN;
        halted <= 1'b0;
      end
    end else if (!stall) begin
      case (state)
        RUN: begin
          if (oob) begin
            state <= ERR;
            exc   <= 1'b1;
          end else if (is_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            pc <= pc_plus2;
          end
        end
        default: ;  // HALT and ERR hold the PC
      endcase
    end
  end

  fetch_ifid_reg #(
    .AW(INST_ADDR_WIDTH),
    .DW(INST_DATA_BIT_WIDTH)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .inst_in    (imem.imem_data),
    .pc_next_in (pc_plus2),
    .inst       (ifid_inst),
    .pc_next    (ifid_pc_next),
    .valid      (ifid_valid)
  );

endmodule
